// File: rtl/detector_ctrl.sv
// SPI register bank and vsync-aligned capture sequencer for the ball detector.
// Holds colour thresholds, arms single/continuous captures, latches X/Y for readback.
`timescale 1ns/1ps
module detector_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       inclk,
  input  logic       res,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       cs,
  output logic       spi_miso,
  input  logic       avsync,
  input  logic       det_valid,
  input  logic [9:0] det_x,
  input  logic [8:0] det_y,
  output logic [6:0] hue_lo,
  output logic [6:0] hue_hi,
  output logic [4:0] sat_min,
  output logic [4:0] val_min,
  output logic       capture_en,
  output logic       busy,
  output logic [7:0] led
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_FRAME = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_vs_sync;
  logic r_sclk_d, r_cs_d, r_vs_d;

  // NOTE: every sequential block uses non-blocking (<=) so all flops sample pre-edge values.
  always_ff @(posedge inclk or posedge res) begin
    if (res) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_vs_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_vs_sync   <= {r_vs_sync[SYNC_STAGES-2:0], avsync};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_vs_d      <= r_vs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_mosi, w_cs, w_vs;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_vs_rise, w_vs_fall;
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_vs        = r_vs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_vs_rise   = w_vs & ~r_vs_d;
  assign w_vs_fall   = ~w_vs & r_vs_d;

  logic [4:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [6:0] r_addr;
  logic       r_rw;
  logic [7:0] r_tx;
  logic       r_cs_seen;
  logic [6:0] r_hue_lo, r_hue_hi;
  logic [4:0] r_sat_min, r_val_min;
  logic       r_cont, r_result_valid, r_miss;
  logic [9:0] r_x;
  logic [8:0] r_y;
  state_t     r_state, w_next_state;

  // A frame only counts once cs has been seen high, so a reset mid-frame needs a fresh cs cycle.
  logic w_active, w_bit_rise, w_commit, w_arm_wr;
  logic [6:0] w_raddr;
  logic [7:0] w_rdata;
  assign w_active   = r_cs_seen & ~w_cs;
  assign w_bit_rise = w_active & w_sclk_rise & (r_bit_cnt != 5'd16);
  assign w_raddr    = {r_rx[5:0], w_mosi};
  assign w_commit   = w_bit_rise & (r_bit_cnt == 5'd15) & ~r_rw;
  assign w_arm_wr   = w_commit & (r_addr == 7'h00) & w_mosi;

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    w_rdata = 8'h00;
    case (w_raddr)
      7'h00:   w_rdata = {6'b0, r_cont, 1'b0};
      7'h01:   w_rdata = {1'b0, r_hue_lo};
      7'h02:   w_rdata = {1'b0, r_hue_hi};
      7'h03:   w_rdata = {3'b0, r_sat_min};
      7'h04:   w_rdata = {3'b0, r_val_min};
      7'h05:   w_rdata = {5'b0, r_miss, r_result_valid, (r_state != S_IDLE)};
      7'h06:   w_rdata = r_x[7:0];
      7'h07:   w_rdata = {6'b0, r_x[9:8]};
      7'h08:   w_rdata = r_y[7:0];
      7'h09:   w_rdata = {7'b0, r_y[8]};
      default: ;
    endcase
  end

  always_ff @(posedge inclk or posedge res) begin
    if (res) begin
      r_bit_cnt <= 5'd0;
      r_rx      <= 7'd0;
      r_addr    <= 7'd0;
      r_rw      <= 1'b0;
      r_tx      <= 8'd0;
      r_cs_seen <= 1'b0;
    end else begin
      if (w_cs) r_cs_seen <= 1'b1;
      if (w_cs_rise) begin
        r_bit_cnt <= 5'd0;
        r_tx      <= 8'd0;
      end else if (w_bit_rise) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        r_rx      <= {r_rx[5:0], w_mosi};
        if (r_bit_cnt == 5'd7) begin
          r_addr <= w_raddr;
          r_rw   <= r_rx[6];
          if (r_rx[6]) r_tx <= w_rdata;
        end
      end else if (w_active && w_sclk_fall && r_bit_cnt >= 5'd8) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // Write data byte is {r_rx, w_mosi} at the 16th rise; bit1 of it is r_rx[0].
  always_ff @(posedge inclk or posedge res) begin
    if (res) begin
      r_hue_lo  <= 7'h00;
      r_hue_hi  <= 7'h7F;
      r_sat_min <= 5'h00;
      r_val_min <= 5'h00;
      r_cont    <= 1'b0;
    end else if (w_commit) begin
      case (r_addr)
        7'h00:   r_cont    <= r_rx[0];
        7'h01:   r_hue_lo  <= {r_rx[5:0], w_mosi};
        7'h02:   r_hue_hi  <= {r_rx[5:0], w_mosi};
        7'h03:   r_sat_min <= {r_rx[3:0], w_mosi};
        7'h04:   r_val_min <= {r_rx[3:0], w_mosi};
        default: ;
      endcase
    end
  end

  always_ff @(posedge inclk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_arm_wr) w_next_state = S_ARM;
      S_ARM:   if (w_vs_fall) w_next_state = S_FRAME;
      S_FRAME: if (det_valid || w_vs_rise) w_next_state = r_cont ? S_ARM : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // det_valid takes priority over the frame-end rise, so a coincident pulse is a hit.
  always_ff @(posedge inclk or posedge res) begin
    if (res) begin
      r_result_valid <= 1'b0;
      r_miss         <= 1'b0;
      r_x            <= 10'd0;
      r_y            <= 9'd0;
    end else if (r_state == S_IDLE && w_arm_wr) begin
      r_result_valid <= 1'b0;
      r_miss         <= 1'b0;
    end else if (r_state == S_FRAME) begin
      if (det_valid) begin
        r_x            <= det_x;
        r_y            <= det_y;
        r_result_valid <= 1'b1;
      end else if (w_vs_rise) begin
        r_miss <= 1'b1;
      end
    end
  end

  always_comb begin
    capture_en = (r_state == S_FRAME);
    busy       = (r_state != S_IDLE);
    led        = {(r_state != S_IDLE), r_result_valid, r_miss, 3'b000, r_state};
  end

  assign spi_miso = r_tx[7];
  assign hue_lo   = r_hue_lo;
  assign hue_hi   = r_hue_hi;
  assign sat_min  = r_sat_min;
  assign val_min  = r_val_min;

endmodule

// File: tb/tb_detector_ctrl.sv
// Self-checking bench for detector_ctrl: directed SPI/capture scenarios plus randomized
// register traffic and frames, compared against a register-level reference model.
`timescale 1ns/1ps
module tb_detector_ctrl;

  localparam int SYNC = 2;
  localparam int HALF = 80;

  logic       inclk = 1'b0;
  logic       res = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       cs = 1'b1;
  logic       avsync = 1'b1;
  logic       det_valid = 1'b0;
  logic [9:0] det_x = '0;
  logic [8:0] det_y = '0;
  logic       spi_miso, capture_en, busy;
  logic [6:0] hue_lo, hue_hi;
  logic [4:0] sat_min, val_min;
  logic [7:0] led;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents and capture status as the host sees them.
  logic [6:0] m_hue_lo = 7'h00, m_hue_hi = 7'h7F;
  logic [4:0] m_sat = 5'h00, m_val = 5'h00;
  logic       m_cont = 1'b0, m_busy = 1'b0, m_rv = 1'b0, m_miss = 1'b0;
  logic [9:0] m_x = '0;
  logic [8:0] m_y = '0;

  detector_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .inclk(inclk), .res(res), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .cs(cs),
    .spi_miso(spi_miso), .avsync(avsync), .det_valid(det_valid), .det_x(det_x),
    .det_y(det_y), .hue_lo(hue_lo), .hue_hi(hue_hi), .sat_min(sat_min),
    .val_min(val_min), .capture_en(capture_en), .busy(busy), .led(led)
  );

  always #5 inclk = ~inclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h00:   return {6'b0, m_cont, 1'b0};
      7'h01:   return {1'b0, m_hue_lo};
      7'h02:   return {1'b0, m_hue_hi};
      7'h03:   return {3'b0, m_sat};
      7'h04:   return {3'b0, m_val};
      7'h05:   return {5'b0, m_miss, m_rv, m_busy};
      7'h06:   return m_x[7:0];
      7'h07:   return {6'b0, m_x[9:8]};
      7'h08:   return m_y[7:0];
      7'h09:   return {7'b0, m_y[8]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h00: begin
        if (d[0] && !m_busy) begin m_busy = 1'b1; m_rv = 1'b0; m_miss = 1'b0; end
        m_cont = d[1];
      end
      7'h01: m_hue_lo = d[6:0];
      7'h02: m_hue_hi = d[6:0];
      7'h03: m_sat = d[4:0];
      7'h04: m_val = d[4:0];
      default: ;
    endcase
  endtask

  // Outside a frame the sequencer is either idle (0) or waiting for vsync (1).
  task automatic check_ports(input string tag);
    check({tag, ".hue_lo"}, 32'(hue_lo), 32'(m_hue_lo));
    check({tag, ".hue_hi"}, 32'(hue_hi), 32'(m_hue_hi));
    check({tag, ".sat_min"}, 32'(sat_min), 32'(m_sat));
    check({tag, ".val_min"}, 32'(val_min), 32'(m_val));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".led"}, 32'(led), 32'({m_busy, m_rv, m_miss, 3'b000, 1'b0, m_busy}));
  endtask

  task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                          output logic [7:0] rd);
    logic [15:0] word;
    word = {b0, b1};
    rd = 8'h00;
    @(negedge inclk);
    cs = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b1;
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      if (i >= 7 && i < 15) rd = {rd[6:0], spi_miso};
      spi_clk = 1'b0;
    end
    #HALF;
    cs = 1'b1;
    spi_mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    spi_xfer({1'b0, a}, d, 16, rd);
    model_write(a, d);
  endtask

  task automatic read_check(input string tag, input logic [6:0] a);
    logic [7:0] rd;
    spi_xfer({1'b1, a}, 8'h00, 16, rd);
    check(tag, 32'(rd), 32'(model_read(a)));
  endtask

  // One camera frame: vsync falls, optional detection, vsync rises.
  task automatic run_frame(input string tag, input bit do_det, input bit coinc,
                           input logic [9:0] x, input logic [8:0] y);
    logic was_armed;
    @(negedge inclk);
    avsync = 1'b0;
    repeat (SYNC + 2) @(negedge inclk);
    check({tag, ".capture_en_on"}, 32'(capture_en), 32'(m_busy));
    was_armed = m_busy;
    repeat (10) @(negedge inclk);
    det_x = x;
    det_y = y;
    if (do_det && !coinc) begin
      det_valid = 1'b1;
      @(negedge inclk);
      det_valid = 1'b0;
      repeat (5) @(negedge inclk);
      avsync = 1'b1;
    end else if (do_det) begin
      avsync = 1'b1;
      repeat (SYNC) @(negedge inclk);
      det_valid = 1'b1;
      @(negedge inclk);
      det_valid = 1'b0;
    end else begin
      avsync = 1'b1;
    end
    repeat (SYNC + 3) @(negedge inclk);
    if (was_armed) begin
      if (do_det) begin m_rv = 1'b1; m_x = x; m_y = y; end
      else m_miss = 1'b1;
      m_busy = m_cont;
    end
    check({tag, ".capture_en_off"}, 32'(capture_en), 32'(0));
    check_ports(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic [6:0] a;
    logic [7:0] d;

    repeat (3) @(negedge inclk);
    res = 1'b0;
    repeat (5) @(negedge inclk);
    check_ports("reset");
    check("reset.capture_en", 32'(capture_en), 32'(0));
    check("reset.spi_miso", 32'(spi_miso), 32'(0));

    read_check("rd_hue_hi_reset", 7'h02);
    read_check("rd_status_reset", 7'h05);

    spi_write(7'h01, 8'h2A);
    check_ports("wr_hue_lo");
    read_check("rd_hue_lo", 7'h01);

    spi_xfer(8'h03, 8'h1B, 11, rd);
    check_ports("abort_sat");
    read_check("rd_sat_after_abort", 7'h03);

    spi_xfer(8'h02, 8'h35, 24, rd);
    model_write(7'h02, 8'h35);
    check_ports("long_frame");
    check("long_frame.miso_idle", 32'(spi_miso), 32'(0));

    spi_write(7'h00, 8'h01);
    check_ports("arm_single");
    run_frame("frame_hit", 1'b1, 1'b0, 10'h2C5, 9'h123);
    for (int r = 6; r <= 9; r++) read_check("rd_xy", 7'(r));
    read_check("rd_status_hit", 7'h05);

    // A pulse while idle must not disturb the latched position.
    run_frame("frame_idle", 1'b1, 1'b0, 10'h111, 9'h0AB);
    read_check("rd_x_idle", 7'h06);

    spi_write(7'h00, 8'h03);
    check_ports("arm_cont");
    run_frame("frame_miss_cont", 1'b0, 1'b0, 10'h0, 9'h0);
    read_check("rd_status_cont_miss", 7'h05);
    read_check("rd_ctrl_cont", 7'h00);
    spi_write(7'h00, 8'h00);
    check_ports("cont_off");
    run_frame("frame_last", 1'b0, 1'b0, 10'h0, 9'h0);
    read_check("rd_status_after_stop", 7'h05);

    spi_write(7'h00, 8'h01);
    run_frame("frame_coinc", 1'b1, 1'b1, 10'h155, 9'h0AA);
    read_check("rd_status_coinc", 7'h05);
    read_check("rd_x_hi_coinc", 7'h07);

    for (int i = 0; i < 20; i++) begin
      a = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 1) == 1) a = 7'($urandom_range(1, 12));
      d = 8'($urandom);
      spi_write(a, d);
      check_ports("rand_wr");
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
      read_check("rand_rd", a);
    end

    for (int i = 0; i < 4; i++) begin
      spi_write(7'h00, 8'h01);
      run_frame("rand_frame", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                10'($urandom), 9'($urandom));
      read_check("rand_status", 7'h05);
      read_check("rand_x_lo", 7'h06);
      read_check("rand_y_hi", 7'h09);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
